// File: rtl/snes_poll_ctrl.sv
// Periodic SNES controller poller with two-scan debounce, sticky press/release
// flags and an Avalon-MM register interface with a level interrupt.
module snes_poll_ctrl #(
    parameter int unsigned POLL_DIV = 833333,
    parameter int unsigned TIMEOUT  = 20000
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic [11:0] snes_buttons,
    input  logic        snes_finish,
    input  logic        snes_idle,
    output logic        snes_start,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_WAIT_TICK,
        S_START,
        S_BUSY,
        S_UPDATE
    } state_t;

    state_t state, state_n;

    logic [DIV_W-1:0] div_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             tick;

    logic        enable, irq_en, timeout_flag;
    logic [11:0] stable, prev_sample, press, release_flags;

    logic        start_n, timeout_set, do_update;
    logic [11:0] sample_new, agree, stable_new, press_set, release_set;
    logic        wr_ctrl, wr_press, wr_release;
    logic [31:0] rd_mux;

    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:12];

    // Free-running divider; a tick outside S_WAIT_TICK is simply not acted on.
    assign tick = (div_cnt == DIV_W'(POLL_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_WAIT_TICK;
            to_cnt     <= '0;
            snes_start <= 1'b0;
        end else begin
            state      <= state_n;
            snes_start <= start_n;
            to_cnt     <= (state == S_BUSY) ? to_cnt + 1'b1 : '0;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        start_n     = 1'b0;
        timeout_set = 1'b0;
        do_update   = 1'b0;
        case (state)
            S_WAIT_TICK: if (tick && enable) state_n = S_START;
            S_START: begin
                if (snes_idle) begin
                    start_n = 1'b1;
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                if (snes_finish) begin
                    state_n = S_UPDATE;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_n     = S_WAIT_TICK;
                end
            end
            S_UPDATE: begin
                do_update = 1'b1;
                state_n   = S_WAIT_TICK;
            end
            default: state_n = S_WAIT_TICK;
        endcase
    end

    // A bit becomes stable only when two consecutive scans agree on it.
    always_comb begin
        sample_new  = ~snes_buttons;
        agree       = ~(sample_new ^ prev_sample);
        stable_new  = (stable & ~agree) | (sample_new & agree);
        press_set   = do_update ? (stable_new & ~stable) : 12'h000;
        release_set = do_update ? (stable & ~stable_new) : 12'h000;
    end

    assign wr_ctrl    = avs_write && (avs_address == 2'd0);
    assign wr_press   = avs_write && (avs_address == 2'd2);
    assign wr_release = avs_write && (avs_address == 2'd3);

    // W1C clears are applied before sets, so a coincident set wins.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            enable        <= 1'b0;
            irq_en        <= 1'b0;
            timeout_flag  <= 1'b0;
            stable        <= '0;
            prev_sample   <= '0;
            press         <= '0;
            release_flags <= '0;
        end else begin
            if (wr_ctrl) begin
                enable <= avs_writedata[0];
                irq_en <= avs_writedata[1];
            end
            timeout_flag  <= (timeout_flag & ~(wr_ctrl & avs_writedata[2])) | timeout_set;
            press         <= (press & ~(wr_press ? avs_writedata[11:0] : 12'h000)) | press_set;
            release_flags <= (release_flags & ~(wr_release ? avs_writedata[11:0] : 12'h000))
                             | release_set;
            if (do_update) begin
                stable      <= stable_new;
                prev_sample <= sample_new;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            2'd0: rd_mux = {29'd0, timeout_flag, irq_en, enable};
            2'd1: rd_mux = {20'd0, stable};
            2'd2: rd_mux = {20'd0, press};
            2'd3: rd_mux = {20'd0, release_flags};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            avs_readdata <= avs_read ? rd_mux : 32'd0;
            irq          <= irq_en & ((|press) | (|release_flags) | timeout_flag);
        end
    end

endmodule

// File: tb/tb_snes_poll_ctrl.sv
// Directed bench for snes_poll_ctrl: a scanner stand-in, a register-level
// reference model, and a per-cycle irq/start-pulse comparison.
module tb_snes_poll_ctrl;

    localparam int POLL_DIV = 100;
    localparam int TIMEOUT  = 50;

    logic        clk_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] snes_buttons = 12'hFFF;
    logic        snes_finish = 1'b0;
    logic        snes_idle;
    logic        snes_start;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        irq;

    logic scan_idle = 1'b1;
    logic idle_block = 1'b0;
    assign snes_idle = scan_idle & ~idle_block;

    snes_poll_ctrl #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk_50       (clk_50),
        .reset_n      (reset_n),
        .snes_buttons (snes_buttons),
        .snes_finish  (snes_finish),
        .snes_idle    (snes_idle),
        .snes_start   (snes_start),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .irq          (irq)
    );

    always #10 clk_50 = ~clk_50;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Clock edges since reset release; ticks land on multiples of POLL_DIV.
    int cyc;
    always @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Reference model of the programmer-visible registers.
    logic        m_enable = 0, m_irq_en = 0, m_timeout = 0;
    logic [11:0] m_stable = 0, m_prev = 0, m_press = 0, m_release = 0;

    function automatic void model_write(input logic [1:0] a, input logic [31:0] d);
        case (a)
            2'd0: begin
                m_enable = d[0];
                m_irq_en = d[1];
                if (d[2]) m_timeout = 1'b0;
            end
            2'd2: m_press   = m_press & ~d[11:0];
            2'd3: m_release = m_release & ~d[11:0];
            default: ;
        endcase
    endfunction

    function automatic void model_scan(input logic [11:0] raw);
        logic [11:0] pressed;
        pressed = ~raw;
        for (int i = 0; i < 12; i++) begin
            if (pressed[i] == m_prev[i] && pressed[i] != m_stable[i]) begin
                if (pressed[i]) m_press[i] = 1'b1;
                else            m_release[i] = 1'b1;
                m_stable[i] = pressed[i];
            end
        end
        m_prev = pressed;
    endfunction

    function automatic logic [31:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_timeout, m_irq_en, m_enable};
            2'd1:    return {20'd0, m_stable};
            2'd2:    return {20'd0, m_press};
            default: return {20'd0, m_release};
        endcase
    endfunction

    function automatic logic model_irq();
        return m_irq_en && (m_press != 0 || m_release != 0 || m_timeout);
    endfunction

    // Scanner stand-in: answers each start pulse after scan_len cycles, or
    // never when scan_hang is set.
    logic [11:0] scan_buttons = 12'hFFF;
    int  scan_len = 3;
    bit  scan_hang = 0, collide = 0, align_chk = 1;
    int  n_starts = 0, n_scans = 0, last_start_cyc = 0;

    initial forever begin
        @(negedge clk_50);
        if (snes_start === 1'b1) begin
            last_start_cyc = cyc;
            n_starts++;
            if (align_chk) check("start_on_tick", 32'(cyc % POLL_DIV), 32'd1);
            scan_idle = 1'b0;
            if (scan_hang) begin
                repeat (TIMEOUT) @(posedge clk_50);
                #1 m_timeout = 1'b1;
            end else begin
                repeat (scan_len) @(posedge clk_50);
                #1;
                snes_buttons = scan_buttons;
                snes_finish  = 1'b1;
                @(posedge clk_50);
                #1;
                snes_finish = 1'b0;
                if (collide) begin
                    avs_address   = 2'd2;
                    avs_writedata = 32'hFFF;
                    avs_write     = 1'b1;
                end
                @(posedge clk_50);
                #1;
                if (collide) begin
                    avs_write = 1'b0;
                    model_write(2'd2, 32'hFFF);
                end
                model_scan(snes_buttons);
            end
            scan_idle = 1'b1;
            n_scans++;
        end
    end

    // Per-cycle comparison: irq follows the model one cycle late, start is a single pulse.
    logic irq_exp_q = 1'b0;
    logic prev_start = 1'b0;
    initial begin
        @(posedge reset_n);
        forever begin
            @(negedge clk_50);
            check("irq", irq, irq_exp_q);
            check("start_pulse_width", snes_start & prev_start, 1'b0);
            prev_start = snes_start;
            irq_exp_q  = model_irq();
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_50);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk_50);
        #1;
        avs_write = 1'b0;
        model_write(a, d);
    endtask

    task automatic rd(input logic [1:0] a, input string name, output logic [31:0] d);
        logic [31:0] exp;
        @(negedge clk_50);
        avs_address = a;
        avs_read    = 1'b1;
        exp         = model_reg(a);
        @(posedge clk_50);
        #1;
        avs_read = 1'b0;
        d = avs_readdata;
        check(name, d, exp);
        @(posedge clk_50);
        #1 check({name, "_idle_zero"}, avs_readdata, 32'd0);
    endtask

    task automatic wait_scans(input int n);
        int target;
        target = n_scans + n;
        for (int i = 0; i < (n + 2) * POLL_DIV && n_scans < target; i++) @(negedge clk_50);
        check("scan_wait", n_scans, target);
    endtask

    task automatic wait_start();
        int target;
        target = n_starts + 1;
        for (int i = 0; i < 3 * POLL_DIV && n_starts < target; i++) @(negedge clk_50);
        check("start_wait", n_starts, target);
    endtask

    initial begin
        logic [31:0] d;
        int s0, n0, r;

        repeat (3) @(negedge clk_50);
        check("rst_snes_start", snes_start, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_readdata", avs_readdata, 32'd0);
        reset_n = 1'b1;

        rd(2'd0, "ctrl_rst", d);     check("ctrl_rst_lit", d, 32'h0);
        rd(2'd1, "buttons_rst", d);  check("buttons_rst_lit", d, 32'h0);

        // Two agreeing scans with button 0 pressed.
        wr(2'd0, 32'h3);
        scan_buttons = 12'hFFE;
        wait_scans(2);
        check("irq_before_latency", irq, 1'b0);
        @(posedge clk_50);
        #1 check("irq_after_press", irq, 1'b1);
        rd(2'd1, "buttons_press", d); check("buttons_press_lit", d, 32'h001);
        rd(2'd2, "press_set", d);     check("press_set_lit", d, 32'h001);

        // Clear PRESS, then release the button.
        wr(2'd2, 32'h001);
        scan_buttons = 12'hFFF;
        wait_scans(2);
        rd(2'd2, "press_clr", d);       check("press_clr_lit", d, 32'h000);
        rd(2'd3, "release_set", d);     check("release_set_lit", d, 32'h001);
        rd(2'd1, "buttons_release", d); check("buttons_release_lit", d, 32'h000);

        // Single-scan glitch must not reach the stable state.
        wr(2'd3, 32'hFFF);
        scan_buttons = 12'hFFE; wait_scans(1);
        scan_buttons = 12'hFFF; wait_scans(1);
        wait_scans(1);
        rd(2'd1, "buttons_glitch", d); check("buttons_glitch_lit", d, 32'h000);
        rd(2'd2, "press_glitch", d);   check("press_glitch_lit", d, 32'h000);

        // Scanner never finishes: timeout flag, no update, restart on the next tick.
        scan_hang = 1;
        wait_scans(1);
        s0 = last_start_cyc;
        scan_hang = 0;
        rd(2'd0, "ctrl_timeout", d);     check("ctrl_timeout_lit", d, 32'h7);
        rd(2'd1, "buttons_timeout", d);  check("buttons_timeout_lit", d, 32'h000);
        wait_start();
        check("restart_next_tick", 32'(last_start_cyc), 32'(s0 + POLL_DIV));
        wait_scans(1);
        wr(2'd0, 32'h7);
        rd(2'd0, "ctrl_timeout_clr", d); check("ctrl_timeout_clr_lit", d, 32'h3);

        // Disable mid-scan: the scan finishes and updates, then polling stops.
        scan_len = 8;
        scan_buttons = 12'hFFE;
        wait_scans(1);
        wait_start();
        wr(2'd0, 32'h2);
        wait_scans(1);
        rd(2'd1, "buttons_disable", d); check("buttons_disable_lit", d, 32'h001);
        n0 = n_starts;
        repeat (5 * POLL_DIV) @(negedge clk_50);
        check("no_start_disabled", n_starts, n0);

        // A PRESS set coinciding with a W1C of the same bit keeps the bit.
        scan_len = 3;
        wr(2'd2, 32'hFFF);
        wr(2'd3, 32'hFFF);
        wr(2'd0, 32'h3);
        scan_buttons = 12'hFFF;
        wait_scans(2);
        wr(2'd3, 32'hFFF);
        scan_buttons = 12'hFFE;
        wait_scans(1);
        collide = 1;
        wait_scans(1);
        collide = 0;
        rd(2'd2, "press_collide", d); check("press_collide_lit", d, 32'h001);

        // Scanner busy at the tick: start waits for idle.
        wr(2'd2, 32'hFFF);
        align_chk = 0;
        idle_block = 1'b1;
        n0 = n_starts;
        repeat (POLL_DIV + 30) @(negedge clk_50);
        check("no_start_while_not_idle", n_starts, n0);
        r = cyc;
        idle_block = 1'b0;
        wait_start();
        check("start_on_idle", 32'(last_start_cyc), 32'(r + 1));
        wait_scans(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/snes_poll_ctrl.md
SNES_POLL_CTRL -- requirements
Module: snes_poll_ctrl

Interface
REQ-001 Parameter POLL_DIV, default 833333, is the number of clk_50 cycles between scan starts (60 Hz at 50 MHz).
REQ-002 Parameter TIMEOUT, default 20000, is the maximum number of clk_50 cycles allowed from start to finish.
REQ-003 The block SHALL use one clock, clk_50, and an asynchronous active-low reset, reset_n.
REQ-004 Ports SHALL be exactly as follows:
- clk_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- snes_buttons  in  12  raw scanner result; 0 = pressed; stable after snes_finish
- snes_finish  in  1  one-cycle scanner done pulse
- snes_idle  in  1  scanner in idle state
- snes_start  out  1  one-cycle scan request
- avs_address  in  2  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered
- irq  out  1  level interrupt

Function
REQ-005 The FSM SHALL have exactly four states: S_WAIT_TICK, S_START, S_BUSY and S_UPDATE.
REQ-006 In S_WAIT_TICK, the divider counts to POLL_DIV-1 and then wraps to 0; on wrap, if CTRL.enable=1, the FSM goes to S_START.
REQ-007 In S_START, if snes_idle=1, the FSM asserts snes_start for exactly one cycle and goes to S_BUSY; otherwise it holds in S_START with snes_start=0.
REQ-008 In S_BUSY, the timeout counter increments each cycle.
- snes_finish=1: go to S_UPDATE.
- Count reaches TIMEOUT-1 without finish: set STATUS.timeout, skip the update, go to S_WAIT_TICK.
REQ-009 In S_UPDATE, the block SHALL register sample = ~snes_buttons and then return to S_WAIT_TICK (one cycle in S_UPDATE).
REQ-010 Debounce: stable[i] takes sample[i] only when sample[i] equals the previous sample[i], meaning two consecutive scans agree.
REQ-011 On each stable 0->1 change, PRESS[i] SHALL be set; on each stable 1->0 change, RELEASE[i] SHALL be set; both are sticky.
REQ-012 The divider SHALL run continuously, independent of the FSM state; a tick that occurs outside S_WAIT_TICK is dropped.
REQ-013 Clearing enable during S_START or S_BUSY SHALL let the current scan complete; no further snes_start is issued while enable=0.
REQ-014 Register map:
- addr 0, CTRL: bit0 enable (RW), bit1 irq_en (RW), bit2 timeout (W1C), bits 31:3 read 0
- addr 1, BUTTONS: bits 11:0 stable (RO); writes ignored
- addr 2, PRESS: bits 11:0 (W1C)
- addr 3, RELEASE: bits 11:0 (W1C)
REQ-015 avs_readdata SHALL be valid on the cycle after avs_read, and SHALL be zero when no read occurred in the previous cycle.
REQ-016 If a W1C clear and a set of the same bit occur in the same cycle, the set SHALL win.
REQ-017 irq SHALL equal irq_en AND (|PRESS OR |RELEASE OR timeout), registered with one cycle of latency.
REQ-018 Unused avs_writedata bits SHALL be ignored.

Reset
REQ-019 On reset_n=0, all of the following SHALL be 0: state = S_WAIT_TICK, divider, timeout counter, enable, irq_en, timeout, stable, previous sample, PRESS, RELEASE, snes_start, avs_readdata and irq.
REQ-020 Assertion of reset_n mid-scan SHALL abort the scan; the scanner is left to finish on its own, and its snes_finish is ignored after reset because the FSM is not in S_BUSY.

Verification (POLL_DIV=100, TIMEOUT=50 in bench)
REQ-021 Write CTRL=0x3, then run two scans with snes_buttons=0xFFE -> BUTTONS reads 0x001, PRESS reads 0x001, and irq=1 one cycle after PRESS sets.
REQ-022 Write PRESS=0x001, then run two scans with snes_buttons=0xFFF -> PRESS reads 0x000, RELEASE reads 0x001, and BUTTONS reads 0x000.
REQ-023 Feed a single-scan glitch (0xFFE, then 0xFFF, then 0xFFF) -> BUTTONS stays 0x000 and PRESS stays 0x000.
REQ-024 Hold snes_finish=0 after start -> CTRL bit2=1 after 50 cycles in S_BUSY, BUTTONS unchanged, and the next snes_start occurs at the following tick.
REQ-025 Write CTRL=0x0 while in S_BUSY -> the scan completes and updates BUTTONS, and no snes_start is issued over 5 tick periods.
REQ-026 In the cycle a set PRESS event occurs, also write PRESS=0xFFF -> bit0 remains 1; separately, holding snes_idle=0 at a tick -> snes_start stays 0 until snes_idle=1.
